// File: rtl/controller_decode_reg_pkg.sv
// Shared encodings for the ID-stage main control unit: opcodes, control codes,
// bundle field positions and helpers that pack fields into EX/M/WB bundles.
package controller_decode_reg_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_AND   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_SP2   = 4'b0111;
  localparam logic [3:0] ALU_SIGN  = 4'b1000;
  localparam logic [3:0] ALU_JUMP  = 4'b1111;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC8 = 2'b10;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int EX_REGDST_LSB   = 7;
  localparam int EX_ALUSRC       = 6;
  localparam int EX_ALUOP_LSB    = 2;
  localparam int EX_ZEROEXT      = 1;
  localparam int EX_REGIMM       = 0;
  localparam int M_BRANCH        = 4;
  localparam int M_MEMREAD       = 3;
  localparam int M_MEMWRITE      = 2;
  localparam int M_SIZE_LSB      = 0;
  localparam int WB_REGWRITE     = 3;
  localparam int WB_MEMTOREG_LSB = 1;
  localparam int WB_SIGNEDLOAD   = 0;

  function automatic logic [8:0] pack_ex(input logic [1:0] reg_dst, input logic alu_src,
                                         input logic [3:0] alu_op, input logic zero_ext,
                                         input logic reg_imm);
    logic [8:0] ex;
    ex = '0;
    ex[EX_REGDST_LSB +: 2] = reg_dst;
    ex[EX_ALUSRC]          = alu_src;
    ex[EX_ALUOP_LSB +: 4]  = alu_op;
    ex[EX_ZEROEXT]         = zero_ext;
    ex[EX_REGIMM]          = reg_imm;
    return ex;
  endfunction

  function automatic logic [4:0] pack_m(input logic branch, input logic mem_read,
                                        input logic mem_write, input logic [1:0] size);
    logic [4:0] m;
    m = '0;
    m[M_BRANCH]        = branch;
    m[M_MEMREAD]       = mem_read;
    m[M_MEMWRITE]      = mem_write;
    m[M_SIZE_LSB +: 2] = size;
    return m;
  endfunction

  function automatic logic [3:0] pack_wb(input logic reg_write, input logic [1:0] mem_to_reg,
                                         input logic signed_load);
    logic [3:0] wb;
    wb = '0;
    wb[WB_REGWRITE]          = reg_write;
    wb[WB_MEMTOREG_LSB +: 2] = mem_to_reg;
    wb[WB_SIGNEDLOAD]        = signed_load;
    return wb;
  endfunction

endpackage

// File: rtl/controller_decode_reg_comb.sv
// Pure combinational opcode decode into the next EX/M/WB/ID control bundles.
// Unlisted opcodes fall through to the all-zero NOP bundle.
module controller_decode_reg_comb
  import controller_decode_reg_pkg::*;
(
  input  logic [5:0] op_code,
  output logic [8:0] ex,
  output logic [4:0] m,
  output logic [3:0] wb,
  output logic       id
);

  always_comb begin
    ex = '0;
    m  = '0;
    wb = '0;
    id = 1'b0;
    case (op_code)
      OP_RTYPE:    begin ex = pack_ex(RD_RD, 1'b0, ALU_RTYPE, 1'b0, 1'b0); wb = pack_wb(1'b1, MTR_ALU, 1'b0); end
      OP_SPECIAL2: begin ex = pack_ex(RD_RD, 1'b0, ALU_SP2, 1'b0, 1'b0);   wb = pack_wb(1'b1, MTR_ALU, 1'b0); end
      OP_REGIMM:   begin ex = pack_ex(RD_RT, 1'b0, ALU_SIGN, 1'b0, 1'b1);  m = pack_m(1'b1, 1'b0, 1'b0, SZ_WORD); end
      OP_J:        begin ex = pack_ex(RD_RT, 1'b0, ALU_JUMP, 1'b0, 1'b0);  id = 1'b1; end
      OP_JAL: begin
        ex = pack_ex(RD_RA, 1'b0, ALU_JUMP, 1'b0, 1'b0);
        wb = pack_wb(1'b1, MTR_PC8, 1'b0);
        id = 1'b1;
      end
      OP_BEQ, OP_BNE:   begin ex = pack_ex(RD_RT, 1'b0, ALU_SUB, 1'b0, 1'b0);  m = pack_m(1'b1, 1'b0, 1'b0, SZ_WORD); end
      OP_BLEZ, OP_BGTZ: begin ex = pack_ex(RD_RT, 1'b0, ALU_SIGN, 1'b0, 1'b0); m = pack_m(1'b1, 1'b0, 1'b0, SZ_WORD); end
      OP_ADDI: begin ex = pack_ex(RD_RT, 1'b1, ALU_ADD, 1'b0, 1'b0); wb = pack_wb(1'b1, MTR_ALU, 1'b0); end
      OP_SLTI: begin ex = pack_ex(RD_RT, 1'b1, ALU_SLT, 1'b0, 1'b0); wb = pack_wb(1'b1, MTR_ALU, 1'b0); end
      OP_ANDI: begin ex = pack_ex(RD_RT, 1'b1, ALU_AND, 1'b1, 1'b0); wb = pack_wb(1'b1, MTR_ALU, 1'b0); end
      OP_ORI:  begin ex = pack_ex(RD_RT, 1'b1, ALU_OR, 1'b1, 1'b0);  wb = pack_wb(1'b1, MTR_ALU, 1'b0); end
      OP_XORI: begin ex = pack_ex(RD_RT, 1'b1, ALU_XOR, 1'b1, 1'b0); wb = pack_wb(1'b1, MTR_ALU, 1'b0); end
      // Loads and stores all compute the address as base + sign-extended offset.
      OP_LW: begin ex = pack_ex(RD_RT, 1'b1, ALU_ADD, 1'b0, 1'b0); m = pack_m(1'b0, 1'b1, 1'b0, SZ_WORD); wb = pack_wb(1'b1, MTR_MEM, 1'b1); end
      OP_LH: begin ex = pack_ex(RD_RT, 1'b1, ALU_ADD, 1'b0, 1'b0); m = pack_m(1'b0, 1'b1, 1'b0, SZ_HALF); wb = pack_wb(1'b1, MTR_MEM, 1'b1); end
      OP_LB: begin ex = pack_ex(RD_RT, 1'b1, ALU_ADD, 1'b0, 1'b0); m = pack_m(1'b0, 1'b1, 1'b0, SZ_BYTE); wb = pack_wb(1'b1, MTR_MEM, 1'b1); end
      OP_SW: begin ex = pack_ex(RD_RT, 1'b1, ALU_ADD, 1'b0, 1'b0); m = pack_m(1'b0, 1'b0, 1'b1, SZ_WORD); end
      OP_SH: begin ex = pack_ex(RD_RT, 1'b1, ALU_ADD, 1'b0, 1'b0); m = pack_m(1'b0, 1'b0, 1'b1, SZ_HALF); end
      OP_SB: begin ex = pack_ex(RD_RT, 1'b1, ALU_ADD, 1'b0, 1'b0); m = pack_m(1'b0, 1'b0, 1'b1, SZ_BYTE); end
      default: ;
    endcase
  end

endmodule

// File: rtl/controller_decode_reg.sv
// ID-stage main control: registers the decoded opcode bundles for the ID/EX path.
// Reset forces the all-zero NOP bundle asynchronously.
module controller_decode_reg
  import controller_decode_reg_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] OpCode,
  output logic [8:0] EX,
  output logic [4:0] M,
  output logic [3:0] WB,
  output logic       ID
);

  logic [8:0] ex_p0;
  logic [4:0] m_p0;
  logic [3:0] wb_p0;
  logic       id_p0;
  logic [8:0] ex_p1;
  logic [4:0] m_p1;
  logic [3:0] wb_p1;
  logic       id_p1;

  controller_decode_reg_comb u_comb (
    .op_code (OpCode),
    .ex      (ex_p0),
    .m       (m_p0),
    .wb      (wb_p0),
    .id      (id_p0)
  );

  // p0 -> p1: decoded bundle captured every cycle, no enable or stall
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ex_p1 <= '0;
      m_p1  <= '0;
      wb_p1 <= '0;
      id_p1 <= 1'b0;
    end else begin
      ex_p1 <= ex_p0;
      m_p1  <= m_p0;
      wb_p1 <= wb_p0;
      id_p1 <= id_p0;
    end
  end

  assign EX = ex_p1;
  assign M  = m_p1;
  assign WB = wb_p1;
  assign ID = id_p1;

endmodule

// File: tb/tb_controller_decode_reg.sv
// Directed bench for controller_decode_reg: hand-written decode table checked
// against registered outputs, including asynchronous reset behaviour.
module tb_controller_decode_reg;

  logic       Clk;
  logic       Reset;
  logic [5:0] OpCode;
  logic [8:0] EX;
  logic [4:0] M;
  logic [3:0] WB;
  logic       ID;

  int checks = 0;
  int errors = 0;

  controller_decode_reg dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .OpCode (OpCode),
    .EX     (EX),
    .M      (M),
    .WB     (WB),
    .ID     (ID)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [18:0] NOP = 19'h0;

  // Expected {EX, M, WB, ID} straight from the opcode table.
  function automatic logic [18:0] expected(input logic [5:0] op);
    case (op)
      6'b000000: return {9'h088, 5'b00000, 4'b1000, 1'b0};
      6'b011100: return {9'h09C, 5'b00000, 4'b1000, 1'b0};
      6'b000001: return {9'h021, 5'b10000, 4'b0000, 1'b0};
      6'b000010: return {9'h03C, 5'b00000, 4'b0000, 1'b1};
      6'b000011: return {9'h13C, 5'b00000, 4'b1100, 1'b1};
      6'b000100: return {9'h004, 5'b10000, 4'b0000, 1'b0};
      6'b000101: return {9'h004, 5'b10000, 4'b0000, 1'b0};
      6'b000110: return {9'h020, 5'b10000, 4'b0000, 1'b0};
      6'b000111: return {9'h020, 5'b10000, 4'b0000, 1'b0};
      6'b001000: return {9'h040, 5'b00000, 4'b1000, 1'b0};
      6'b001010: return {9'h04C, 5'b00000, 4'b1000, 1'b0};
      6'b001100: return {9'h052, 5'b00000, 4'b1000, 1'b0};
      6'b001101: return {9'h056, 5'b00000, 4'b1000, 1'b0};
      6'b001110: return {9'h05A, 5'b00000, 4'b1000, 1'b0};
      6'b100011: return {9'h040, 5'b01000, 4'b1011, 1'b0};
      6'b100001: return {9'h040, 5'b01001, 4'b1011, 1'b0};
      6'b100000: return {9'h040, 5'b01010, 4'b1011, 1'b0};
      6'b101011: return {9'h040, 5'b00100, 4'b0000, 1'b0};
      6'b101001: return {9'h040, 5'b00101, 4'b0000, 1'b0};
      6'b101000: return {9'h040, 5'b00110, 4'b0000, 1'b0};
      default:   return NOP;
    endcase
  endfunction

  task automatic check(input string tag, input logic [18:0] exp);
    logic [18:0] got;
    got = {EX, M, WB, ID};
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: observed EX=%03h M=%05b WB=%04b ID=%0b, expected EX=%03h M=%05b WB=%04b ID=%0b",
               tag, got[18:10], got[9:5], got[4:1], got[0], exp[18:10], exp[9:5], exp[4:1], exp[0]);
      $error("%s observed %05h expected %05h", tag, got, exp);
    end
  endtask

  // Present an opcode mid-cycle and sample just after the capturing edge.
  task automatic step(input logic [5:0] op);
    @(negedge Clk);
    OpCode = op;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset  = 1'b0;
    OpCode = 6'b100011;
    #2;
    check("reset_async", NOP);
    @(posedge Clk); #1;
    check("reset_held_edge", NOP);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("reset_release_no_edge", NOP);
    @(posedge Clk); #1;
    check("lw_after_reset", {9'h040, 5'b01000, 4'b1011, 1'b0});

    step(6'b000000); check("rtype", {9'h088, 5'b00000, 4'b1000, 1'b0});
    step(6'b101011); check("sw_next", {9'h040, 5'b00100, 4'b0000, 1'b0});
    step(6'b000011); check("jal", {9'h13C, 5'b00000, 4'b1100, 1'b1});
    step(6'b000010); check("j", {9'h03C, 5'b00000, 4'b0000, 1'b1});
    step(6'b000100); check("beq", {9'h004, 5'b10000, 4'b0000, 1'b0});
    step(6'b000110); check("blez", {9'h020, 5'b10000, 4'b0000, 1'b0});
    step(6'b000001); check("regimm", {9'h021, 5'b10000, 4'b0000, 1'b0});
    step(6'b001101); check("ori", {9'h056, 5'b00000, 4'b1000, 1'b0});
    step(6'b100000); check("lb", {9'h040, 5'b01010, 4'b1011, 1'b0});
    step(6'b101001); check("sh", {9'h040, 5'b00101, 4'b0000, 1'b0});
    step(6'b111111); check("undef_3f", NOP);
    step(6'b001001); check("undef_09", NOP);

    for (int i = 0; i < 64; i++) begin
      step(6'(i));
      check($sformatf("sweep_op%02h", i), expected(6'(i)));
      if (i == 35) begin
        // Drop reset between edges: output must clear without a clock.
        #2;
        Reset = 1'b0;
        #1;
        check("sweep_reset_async", NOP);
        @(posedge Clk); #1;
        check("sweep_reset_discard", NOP);
        Reset = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
